// File: rtl/cim_lut_responder.sv
// Lookup-table responder for a compute-in-memory AES core: serial AddRoundKey
// followed by a per-lane S-box lookup, repeated for every round.
module cim_lut_responder #(
  parameter int LANES  = 16,
  parameter int DW     = 8,
  parameter int HI_W   = 3,
  parameter int LO_W   = 6,
  parameter int RD_LAT = 1,
  parameter int ROUNDS = 10
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  mode,
  input  logic [LANES-1:0]      IN,
  input  logic [LANES*HI_W-1:0] demux_add,
  input  logic [LANES*LO_W-1:0] rwl_add,
  input  logic                  tbl_we,
  input  logic                  tbl_sel,
  input  logic [HI_W+LO_W-1:0]  tbl_addr,
  input  logic [DW-1:0]         tbl_wdata,
  input  logic                  rk_we,
  input  logic [3:0]            rk_idx,
  input  logic [LANES*DW-1:0]   rk_wdata,
  output logic [LANES*DW-1:0]   rio,
  output logic                  rio_vld,
  output logic                  busy,
  output logic                  done,
  output logic [3:0]            round,
  output logic                  err
);

  localparam int AW    = HI_W + LO_W;
  localparam int DEPTH = 1 << AW;
  localparam int CW    = $clog2(DW + RD_LAT + 1);
  localparam logic [3:0]    LAST_ROUND = 4'(ROUNDS);
  localparam logic [CW-1:0] ARK_LAST   = CW'(DW - 1);
  localparam logic [CW-1:0] RD_ISSUE   = CW'(RD_LAT - 1);

  typedef enum logic [1:0] {IDLE, ARK, LOOKUP, DONE} state_t;

  state_t                state;
  logic [CW-1:0]         c;
  logic                  mode_q;
  logic [DW-1:0]         tbl [2][DEPTH];
  logic [LANES*DW-1:0]   rk [ROUNDS+1];
  logic [AW-1:0]         addr_q [LANES];
  logic [AW-1:0]         rd_addr [LANES];
  logic [LANES*DW-1:0]   key_now;
  logic [LANES*DW-1:0]   ark_rio;
  logic [LANES*DW-1:0]   lk_rio;

  // NOTE: table, key and captured-address storage have no reset; only control state does.
  always_ff @(posedge CLK) begin
    if (tbl_we && !busy)
      tbl[tbl_sel][tbl_addr] <= tbl_wdata;
    if (rk_we && !busy && rk_idx <= LAST_ROUND)
      rk[rk_idx] <= rk_wdata;
    if (state == LOOKUP && c == '0)
      addr_q <= rd_addr;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)
      err <= 1'b0;
    else if (((tbl_we || rk_we) && busy) || (rk_we && rk_idx > LAST_ROUND))
      err <= 1'b1;
  end

  assign key_now = rk[round];

  // NOTE: every always_comb output gets a full default first so no latch is inferred.
  always_comb begin
    ark_rio = rio;
    lk_rio  = rio;
    for (int l = 0; l < LANES; l++) begin
      // The first LOOKUP cycle reads the live ports; later cycles use the capture.
      rd_addr[l] = (c == '0) ? {demux_add[l*HI_W +: HI_W], rwl_add[l*LO_W +: LO_W]}
                             : addr_q[l];
      lk_rio[(LANES-1-l)*DW +: DW] = tbl[mode_q][rd_addr[l]];
      for (int b = 0; b < DW; b++) begin
        if (CW'(DW - 1 - b) == c)
          ark_rio[(LANES-1-l)*DW + b] = IN[l] ^ key_now[(LANES-1-l)*DW + b];
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state   <= IDLE;
      busy    <= 1'b0;
      rio     <= '0;
      rio_vld <= 1'b0;
      done    <= 1'b0;
      round   <= '0;
      c       <= '0;
      mode_q  <= 1'b0;
    end else begin
      rio_vld <= 1'b0;
      done    <= 1'b0;
      if (abort && state != IDLE) begin
        state <= IDLE;
        busy  <= 1'b0;
        round <= '0;
        c     <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              mode_q <= mode;
              round  <= '0;
              c      <= '0;
              busy   <= 1'b1;
              state  <= ARK;
            end
          end
          ARK: begin
            rio <= ark_rio;
            if (c == ARK_LAST) begin
              c     <= '0;
              state <= LOOKUP;
            end else begin
              c <= c + 1'b1;
            end
          end
          LOOKUP: begin
            if (rio_vld) begin
              c <= '0;
              if (round == LAST_ROUND) begin
                done  <= 1'b1;
                state <= DONE;
              end else begin
                round <= round + 1'b1;
                state <= ARK;
              end
            end else begin
              c <= c + 1'b1;
              if (c == RD_ISSUE) begin
                rio     <= lk_rio;
                rio_vld <= 1'b1;
              end
            end
          end
          DONE: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cim_lut_responder.sv
// Randomised bench for cim_lut_responder: a phase-arithmetic reference model is
// compared against the DUT every cycle, plus AES (FIPS-197) literal checkpoints.
module tb_cim_lut_responder;

  localparam int LANES = 16, DW = 8, HI_W = 3, LO_W = 6, RD_LAT = 1, ROUNDS = 10;
  localparam int AW     = HI_W + LO_W;
  localparam int W      = LANES * DW;
  localparam int P      = DW + RD_LAT + 1;       // cycles per round
  localparam int TOT    = (ROUNDS + 1) * P;      // body cycles before DONE
  localparam int OP_CYC = TOT + 1;               // start-to-done cycle count

  logic                  CLK = 1'b0;
  logic                  RSTn;
  logic                  start, abort, mode;
  logic [LANES-1:0]      in_bits;
  logic [LANES*HI_W-1:0] demux_add;
  logic [LANES*LO_W-1:0] rwl_add;
  logic                  tbl_we, tbl_sel;
  logic [AW-1:0]         tbl_addr;
  logic [DW-1:0]         tbl_wdata;
  logic                  rk_we;
  logic [3:0]            rk_idx;
  logic [W-1:0]          rk_wdata;
  logic [W-1:0]          rio;
  logic                  rio_vld, busy, done, err;
  logic [3:0]            round;

  always #5 CLK = ~CLK;

  cim_lut_responder #(.LANES(LANES), .DW(DW), .HI_W(HI_W), .LO_W(LO_W),
                      .RD_LAT(RD_LAT), .ROUNDS(ROUNDS)) dut (
    .CLK(CLK), .RSTn(RSTn), .start(start), .abort(abort), .mode(mode), .IN(in_bits),
    .demux_add(demux_add), .rwl_add(rwl_add), .tbl_we(tbl_we), .tbl_sel(tbl_sel),
    .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata), .rk_we(rk_we), .rk_idx(rk_idx),
    .rk_wdata(rk_wdata), .rio(rio), .rio_vld(rio_vld), .busy(busy), .done(done),
    .round(round), .err(err)
  );

  int n_checks = 0;
  int n_errors = 0;
  int vld_cnt  = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- AES material ----------------
  logic [7:0] sb [256];
  logic [7:0] isb [256];
  logic [W-1:0] aes_rk [ROUNDS+1];

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d = {x, x};
    return d[15-n -: 8];
  endfunction

  task automatic build_aes();
    logic [31:0] w [4*(ROUNDS+1)];
    logic [31:0] t;
    logic [7:0]  inv, rcon;
    logic [127:0] key = 128'h000102030405060708090a0b0c0d0e0f;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    for (int a = 0; a < 256; a++) isb[sb[a]] = 8'(a);
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rcon = 8'h01;
    for (int i = 4; i < 4*(ROUNDS+1); i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rcon, 24'h0};
        rcon = xtime(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= ROUNDS; r++) aes_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- reference model ----------------
  // Tracks "cycles since start" and derives round/bit/lookup timing arithmetically.
  logic [DW-1:0] m_tbl [2][1<<AW];
  logic [W-1:0]  m_rk [16];
  logic [W-1:0]  m_rio;
  logic          m_busy, m_vld, m_done, m_err, m_mode;
  logic [3:0]    m_round;
  int            m_t;
  int            m_capt [LANES];

  task automatic model_reset();
    m_busy = 0; m_vld = 0; m_done = 0; m_err = 0; m_round = 0; m_rio = '0; m_t = 0;
  endtask

  task automatic model_step();
    int r, k, pos;
    if (tbl_we) begin
      if (m_busy) m_err = 1;
      else m_tbl[tbl_sel][tbl_addr] = tbl_wdata;
    end
    if (rk_we) begin
      if (m_busy || int'(rk_idx) > ROUNDS) m_err = 1;
      else m_rk[rk_idx] = rk_wdata;
    end
    m_vld  = 0;
    m_done = 0;
    if (!m_busy) begin
      if (start) begin
        m_busy = 1; m_mode = mode; m_t = 0; m_round = 0;
      end
    end else if (abort) begin
      m_busy = 0; m_round = 0;
    end else if (m_t == TOT) begin
      m_busy = 0;
    end else begin
      r = m_t / P;
      k = m_t % P;
      if (k < DW)
        for (int l = 0; l < LANES; l++) begin
          pos = (LANES-1-l)*DW + DW-1-k;
          m_rio[pos] = in_bits[l] ^ m_rk[r][pos];
        end
      if (k == DW)
        for (int l = 0; l < LANES; l++)
          m_capt[l] = int'({demux_add[l*HI_W +: HI_W], rwl_add[l*LO_W +: LO_W]});
      if (k == DW + RD_LAT - 1) begin
        for (int l = 0; l < LANES; l++)
          m_rio[(LANES-1-l)*DW +: DW] = m_tbl[m_mode][m_capt[l]];
        m_vld = 1;
      end
      m_t++;
      if (m_t == TOT) m_done = 1;
      else m_round = 4'(m_t / P);
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge CLK or negedge RSTn);
      if (!RSTn) model_reset();
      else model_step();
    end
  end

  // One compare process: every cycle, all outputs against the model.
  initial begin
    forever begin
      @(negedge CLK);
      if (rio_vld === 1'b1) vld_cnt++;
      check("rio",     rio,     m_rio);
      check("rio_vld", W'(rio_vld), W'(m_vld));
      check("busy",    W'(busy),    W'(m_busy));
      check("done",    W'(done),    W'(m_done));
      check("round",   W'(round),   W'(m_round));
      check("err",     W'(err),     W'(m_err));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic set_addr(input int a);
    for (int l = 0; l < LANES; l++) begin
      demux_add[l*HI_W +: HI_W] = HI_W'(a >> LO_W);
      rwl_add[l*LO_W +: LO_W]   = LO_W'(a);
    end
  endtask

  task automatic drive_rand();
    in_bits = LANES'($urandom);
    for (int l = 0; l < LANES; l++) begin
      demux_add[l*HI_W +: HI_W] = HI_W'($urandom);
      rwl_add[l*LO_W +: LO_W]   = LO_W'($urandom);
    end
  endtask

  task automatic wait_done(input bit rnd, inout int cnt);
    while (done !== 1'b1 && cnt < 400) begin
      if (rnd) drive_rand();
      tick();
      cnt++;
    end
  endtask

  task automatic wait_vld(input bit rnd_in);
    int n = 0;
    while (rio_vld !== 1'b1 && n < 60) begin
      if (rnd_in) in_bits = LANES'($urandom);
      tick();
      n++;
    end
    check("vld_seen", W'(rio_vld), W'(1));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cnt, v0;
    bit found;
    RSTn = 0; start = 0; abort = 0; mode = 0; in_bits = '0; demux_add = '0; rwl_add = '0;
    tbl_we = 0; tbl_sel = 0; tbl_addr = '0; tbl_wdata = '0; rk_we = 0; rk_idx = '0; rk_wdata = '0;

    build_aes();
    check("model_sbox_00",  W'(sb[8'h00]),  W'(8'h63));
    check("model_sbox_53",  W'(sb[8'h53]),  W'(8'hed));
    check("model_isbox_63", W'(isb[8'h63]), W'(8'h00));
    check("model_rk1", aes_rk[1], 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);

    repeat (3) tick();
    RSTn = 1;
    tick();
    check("rst_rio", rio, '0);
    check("rst_busy", W'(busy), '0);
    check("rst_err", W'(err), '0);

    // Load both tables (upper halves random) and the round keys.
    tbl_we = 1;
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < (1 << AW); a++) begin
        tbl_sel   = s[0];
        tbl_addr  = AW'(a);
        tbl_wdata = (a < 256) ? (s == 0 ? sb[a] : isb[a]) : DW'($urandom);
        tick();
      end
    tbl_we = 0;
    rk_we  = 1;
    for (int r = 0; r <= ROUNDS; r++) begin
      rk_idx = 4'(r); rk_wdata = aes_rk[r];
      tick();
    end
    rk_we = 0;

    // Full forward run, IN=0, all lanes addressing 0x00.
    v0 = vld_cnt;
    start = 1; mode = 0; in_bits = '0; set_addr(8'h00);
    tick(); start = 0;
    repeat (DW) tick();
    check("ark0_rio", rio, 128'h000102030405060708090a0b0c0d0e0f);
    repeat (RD_LAT) tick();
    check("lut_fwd_00", rio, {LANES{8'h63}});
    check("lut_fwd_vld", W'(rio_vld), W'(1));
    repeat (P - RD_LAT) tick();
    check("ark1_rio", rio, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
    check("ark1_round", W'(round), W'(1));
    cnt = DW + P + 1;
    wait_done(0, cnt);
    check("done_cycle", W'(cnt), W'(OP_CYC));
    tick();
    check("vld_pulses", W'(vld_cnt - v0), W'(ROUNDS + 1));

    // Inverse lookup of 0x63, then abort in round 5 LOOKUP.
    start = 1; mode = 1; set_addr(8'h63);
    tick(); start = 0;
    wait_vld(1);
    check("lut_inv_63", rio, '0);
    found = 0;
    for (int n = 0; n < 200 && !found; n++) begin
      if (rio_vld === 1'b1 && round == 4'd5) found = 1;
      else begin in_bits = LANES'($urandom); tick(); end
    end
    check("r5_lookup_seen", W'(found), W'(1));
    abort = 1; tick(); abort = 0;
    check("abort_busy", W'(busy), '0);
    check("abort_done", W'(done), '0);
    check("abort_round", W'(round), '0);

    // Full run after abort with random inputs.
    start = 1; mode = 1'($urandom); drive_rand();
    tick(); start = 0;
    cnt = 1;
    wait_done(1, cnt);
    check("post_abort_done_cycle", W'(cnt), W'(OP_CYC));
    tick();

    // Table write while busy is dropped and sets err.
    start = 1; mode = 0; set_addr(8'h53);
    tick(); start = 0;
    repeat (2) tick();
    tbl_we = 1; tbl_sel = 0; tbl_addr = AW'(8'h53); tbl_wdata = 8'h00;
    tick(); tbl_we = 0;
    check("busy_write_err", W'(err), W'(1));
    cnt = 4;
    wait_done(0, cnt);
    tick();
    start = 1; mode = 0; set_addr(8'h53);
    tick(); start = 0;
    wait_vld(1);
    check("sbox_53_kept", rio, {LANES{8'hed}});

    // Reset mid-ARK: outputs clear at once, tables survive, start on release.
    repeat (3) tick();
    #2 RSTn = 0;
    #1;
    check("midrst_rio", rio, '0);
    check("midrst_busy", W'(busy), '0);
    check("midrst_round", W'(round), '0);
    check("midrst_err", W'(err), '0);
    @(posedge CLK);
    @(negedge CLK);
    RSTn = 1; start = 1; mode = 0; set_addr(8'h53);
    tick(); start = 0;
    check("start_after_rst", W'(busy), W'(1));
    wait_vld(1);
    check("sbox_53_after_rst", rio, {LANES{8'hed}});
    cnt = 0;
    wait_done(1, cnt);
    tick();

    rk_we = 1; rk_idx = 4'd12; rk_wdata = '1;
    tick(); rk_we = 0;
    check("rk_idx_err", W'(err), W'(1));

    // Random operations: concurrent start+write, random aborts and busy writes.
    for (int op = 0; op < 6; op++) begin
      repeat ($urandom_range(0, 3)) begin
        tbl_we = 1; tbl_sel = 1'($urandom); tbl_addr = AW'($urandom); tbl_wdata = DW'($urandom);
        tick();
      end
      tbl_we = 0;
      start = 1; mode = 1'($urandom); drive_rand();
      if (op == 0) begin
        rk_we = 1; rk_idx = 4'd0; rk_wdata = {$urandom, $urandom, $urandom, $urandom};
      end
      tick(); start = 0; rk_we = 0;
      for (int n = 0; n < 400 && busy === 1'b1; n++) begin
        drive_rand();
        abort = ($urandom_range(0, 299) == 0);
        if ($urandom_range(0, 63) == 0) begin
          tbl_we = 1; tbl_sel = 1'($urandom); tbl_addr = AW'($urandom); tbl_wdata = DW'($urandom);
        end
        tick();
        abort = 0; tbl_we = 0;
      end
      check("rand_op_ended", W'(busy), '0);
    end

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
